// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with pause, clamped load and a tick-timed alarm after expiry.
// Optional auto-reload on expiry is enabled by defining TIMER_AUTO_RELOAD_EN.
module bcd_countdown_timer #(
  parameter int unsigned MM_TENS_MAX = 9,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_mm_t,
  input  logic [3:0] load_mm_u,
  input  logic [3:0] load_ss_t,
  input  logic [3:0] load_ss_u,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
`ifdef TIMER_AUTO_RELOAD_EN
  input  logic       repeat_mode,
`endif
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [3:0] ss_t,
  output logic [3:0] ss_u,
  output logic       running,
  output logic       paused,
  output logic       alarm,
  output logic       expired
);

  localparam int unsigned CNT_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] ALARM = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [15:0]      digits_q, digits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_d;
  logic             idle_or_pause;
  logic [15:0]      load_clamped;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [15:0]      reload_q, reload_d;
`endif

  // Saturate each loaded digit to its legal range for its position.
  function automatic logic [15:0] clamp_digits(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
    mt = (mt > 4'(MM_TENS_MAX)) ? 4'(MM_TENS_MAX) : mt;
    mu = (v[11:8] > 4'd9) ? 4'd9 : v[11:8];
    st = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    su = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {mt, mu, st, su};
  endfunction

  // One-second BCD borrow chain; caller guarantees a nonzero input.
  function automatic logic [15:0] dec_digits(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = v;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  assign idle_or_pause = (state_q == IDLE) || (state_q == PAUSE);
  assign load_clamped  = clamp_digits({load_mm_t, load_mm_u, load_ss_t, load_ss_u});

  // Next-state: clear > load > start > pause > tick; ignored commands fall through.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (clear) begin
      state_d  = IDLE;
      digits_d = 16'h0000;
      cnt_d    = '0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_d = 16'h0000;
`endif
    end else if (load && idle_or_pause) begin
      digits_d = load_clamped;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_d = load_clamped;
`endif
    end else if (start && idle_or_pause && (digits_q != 16'h0000)) begin
      state_d = RUN;
    end else if (pause && (state_q == RUN)) begin
      state_d = PAUSE;
    end else if (tick) begin
      case (state_q)
        RUN: begin
          if (digits_q == 16'h0001) begin
            expired_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            if (repeat_mode) begin
              digits_d = reload_q;
            end else begin
              digits_d = 16'h0000;
              state_d  = ALARM;
              cnt_d    = '0;
            end
`else
            digits_d = 16'h0000;
            state_d  = ALARM;
            cnt_d    = '0;
`endif
          end else if (digits_q != 16'h0000) begin
            digits_d = dec_digits(digits_q);
          end
        end
        ALARM: begin
          if (cnt_q == CNT_W'(ALARM_TICKS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State, digits and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= 16'h0000;
      cnt_q    <= '0;
      running  <= 1'b0;
      paused   <= 1'b0;
      alarm    <= 1'b0;
      expired  <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_q <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      running  <= (state_d == RUN);
      paused   <= (state_d == PAUSE);
      alarm    <= (state_d == ALARM);
      expired  <= expired_d;
`ifdef TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign mm_t = digits_q[15:12];
  assign mm_u = digits_q[11:8];
  assign ss_t = digits_q[7:4];
  assign ss_u = digits_q[3:0];

endmodule
